// File: rtl/pingpong_buf_ctrl.sv
// N-bank ping-pong controller: tracks per-bank EMPTY/FILLING/FULL/DRAINING state,
// round-robin fill/drain pointers, and steers each bank's SRAM port to its current owner.
module pingpong_buf_ctrl #(
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 7,
    parameter int BIDX_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      prod_req,
    output logic                      prod_gnt,
    output logic [BIDX_W-1:0]         prod_bank,
    input  logic                      prod_done,
    input  logic [ADDR_W:0]           prod_len,
    input  logic [ADDR_W-1:0]         prod_A,
    input  logic                      prod_CEN,
    input  logic                      prod_WEN,
    output logic                      cons_valid,
    output logic [BIDX_W-1:0]         cons_bank,
    output logic [ADDR_W:0]           cons_len,
    input  logic                      cons_req,
    input  logic                      cons_done,
    input  logic [ADDR_W-1:0]         cons_A,
    input  logic                      cons_CEN,
    output logic [NUM_BUF*ADDR_W-1:0] buf_A,
    output logic [NUM_BUF-1:0]        buf_CEN,
    output logic [NUM_BUF-1:0]        buf_WEN,
    output logic [BIDX_W:0]           full_cnt,
    output logic                      err
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_st_e;

    bank_st_e          st_q   [NUM_BUF];
    bank_st_e          st_d   [NUM_BUF];
    logic [ADDR_W:0]   len_q  [NUM_BUF];
    logic [ADDR_W:0]   len_d  [NUM_BUF];
    logic [BIDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BIDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              prod_gnt_q, prod_gnt_d;
    logic [BIDX_W-1:0] prod_bank_q, prod_bank_d;
    logic [BIDX_W:0]   full_cnt_q, full_cnt_d;
    logic              err_q, err_d;

    logic              any_drain_s;
    bank_st_e          st_wr_s;
    bank_st_e          st_rd_s;
    logic [ADDR_W:0]   len_rd_s;
    logic              cons_valid_s;
    logic              grant_s;
    logic              commit_s;
    logic              dstart_s;
    logic              dend_s;
    logic              proto_err_s;

    // Pointers wrap by comparison so non power-of-two bank counts work.
    function automatic logic [BIDX_W-1:0] next_ptr(input logic [BIDX_W-1:0] p);
        if (p == BIDX_W'(NUM_BUF - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + BIDX_W'(1);
        end
    endfunction

    // State register for all bank bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                st_q[b]  <= ST_EMPTY;
                len_q[b] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            prod_gnt_q  <= 1'b0;
            prod_bank_q <= '0;
            full_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                st_q[b]  <= st_d[b];
                len_q[b] <= len_d[b];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            prod_gnt_q  <= prod_gnt_d;
            prod_bank_q <= prod_bank_d;
            full_cnt_q  <= full_cnt_d;
            err_q       <= err_d;
        end
    end

    // Decode the banks addressed by the pointers without dynamic array indexing.
    always_comb begin
        any_drain_s = 1'b0;
        st_wr_s     = ST_EMPTY;
        st_rd_s     = ST_EMPTY;
        len_rd_s    = '0;
        for (int b = 0; b < NUM_BUF; b++) begin
            if (st_q[b] == ST_DRAINING) begin
                any_drain_s = 1'b1;
            end else begin
                any_drain_s = any_drain_s;
            end
            if (BIDX_W'(b) == wr_ptr_q) begin
                st_wr_s = st_q[b];
            end else begin
                st_wr_s = st_wr_s;
            end
            if (BIDX_W'(b) == rd_ptr_q) begin
                st_rd_s  = st_q[b];
                len_rd_s = len_q[b];
            end else begin
                st_rd_s  = st_rd_s;
                len_rd_s = len_rd_s;
            end
        end
        cons_valid_s = (st_rd_s == ST_FULL) && !any_drain_s;
    end

    // Next-state: grant/commit on the producer side, start/finish on the consumer side.
    always_comb begin
        grant_s     = prod_req && !prod_gnt_q && (st_wr_s == ST_EMPTY);
        commit_s    = prod_done && prod_gnt_q;
        dstart_s    = cons_req && cons_valid_s;
        dend_s      = cons_done && any_drain_s;
        proto_err_s = (prod_done && !prod_gnt_q) || (cons_done && !any_drain_s) ||
                      (cons_req && !cons_valid_s) || (!prod_CEN && !prod_gnt_q) ||
                      (!cons_CEN && !any_drain_s);
        for (int b = 0; b < NUM_BUF; b++) begin
            st_d[b]  = st_q[b];
            len_d[b] = len_q[b];
        end
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        prod_gnt_d  = prod_gnt_q;
        prod_bank_d = prod_bank_q;
        err_d       = err_q;
        full_cnt_d  = '0;

        if (clear) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                st_d[b]  = ST_EMPTY;
                len_d[b] = '0;
            end
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            prod_gnt_d  = 1'b0;
            prod_bank_d = '0;
            err_d       = 1'b0;
        end else begin
            err_d = err_q || proto_err_s;
            if (grant_s) begin
                prod_gnt_d  = 1'b1;
                prod_bank_d = wr_ptr_q;
            end else if (commit_s) begin
                prod_gnt_d = 1'b0;
                if (prod_len != '0) begin
                    wr_ptr_d = next_ptr(wr_ptr_q);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
            end else begin
                prod_gnt_d = prod_gnt_q;
            end
            if (dend_s) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // The four events always target distinct banks, so one priority chain suffices.
            for (int b = 0; b < NUM_BUF; b++) begin
                if (grant_s && (BIDX_W'(b) == wr_ptr_q)) begin
                    st_d[b] = ST_FILLING;
                end else if (commit_s && (BIDX_W'(b) == prod_bank_q)) begin
                    st_d[b]  = (prod_len != '0) ? ST_FULL : ST_EMPTY;
                    len_d[b] = prod_len;
                end else if (dstart_s && (BIDX_W'(b) == rd_ptr_q)) begin
                    st_d[b] = ST_DRAINING;
                end else if (dend_s && (BIDX_W'(b) == rd_ptr_q)) begin
                    st_d[b] = ST_EMPTY;
                end else begin
                    st_d[b] = st_q[b];
                end
            end
        end

        for (int b = 0; b < NUM_BUF; b++) begin
            if (st_d[b] == ST_FULL) begin
                full_cnt_d = full_cnt_d + (BIDX_W + 1)'(1);
            end else begin
                full_cnt_d = full_cnt_d;
            end
        end
    end

    // Per-bank SRAM port steering to the current owner.
    always_comb begin
        buf_A   = '0;
        buf_CEN = '1;
        buf_WEN = '1;
        for (int b = 0; b < NUM_BUF; b++) begin
            case (st_q[b])
                ST_FILLING: begin
                    buf_A[b*ADDR_W +: ADDR_W] = prod_A;
                    buf_CEN[b]                = prod_CEN;
                    buf_WEN[b]                = prod_WEN;
                end
                ST_DRAINING: begin
                    buf_A[b*ADDR_W +: ADDR_W] = cons_A;
                    buf_CEN[b]                = cons_CEN;
                    buf_WEN[b]                = 1'b1;
                end
                default: begin
                    buf_A[b*ADDR_W +: ADDR_W] = '0;
                    buf_CEN[b]                = 1'b1;
                    buf_WEN[b]                = 1'b1;
                end
            endcase
        end
    end

    assign prod_gnt   = prod_gnt_q;
    assign prod_bank  = prod_bank_q;
    assign cons_valid = cons_valid_s;
    assign cons_bank  = rd_ptr_q;
    assign cons_len   = len_rd_s;
    assign full_cnt   = full_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Randomized bench for pingpong_buf_ctrl (3 banks) against a queue-based reference model.
module tb_pingpong_buf_ctrl;

    localparam int NB = 3;
    localparam int AW = 7;
    localparam int BW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            prod_req, prod_done, prod_CEN, prod_WEN;
    logic [AW:0]     prod_len;
    logic [AW-1:0]   prod_A;
    logic            prod_gnt;
    logic [BW-1:0]   prod_bank;
    logic            cons_valid, cons_req, cons_done, cons_CEN;
    logic [BW-1:0]   cons_bank;
    logic [AW:0]     cons_len;
    logic [AW-1:0]   cons_A;
    logic [NB*AW-1:0] buf_A;
    logic [NB-1:0]   buf_CEN, buf_WEN;
    logic [BW:0]     full_cnt;
    logic            err;

    pingpong_buf_ctrl #(.NUM_BUF(NB), .ADDR_W(AW), .BIDX_W(BW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .prod_req(prod_req), .prod_gnt(prod_gnt), .prod_bank(prod_bank),
        .prod_done(prod_done), .prod_len(prod_len), .prod_A(prod_A),
        .prod_CEN(prod_CEN), .prod_WEN(prod_WEN),
        .cons_valid(cons_valid), .cons_bank(cons_bank), .cons_len(cons_len),
        .cons_req(cons_req), .cons_done(cons_done), .cons_A(cons_A), .cons_CEN(cons_CEN),
        .buf_A(buf_A), .buf_CEN(buf_CEN), .buf_WEN(buf_WEN),
        .full_cnt(full_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miss_cnt = 0;

    // Reference model: banks waiting to drain are a FIFO; pointers are fill/drain counts mod NB.
    int filling_m;
    int draining_m;
    int full_q[$];
    int len_m[NB];
    int wr_cnt;
    int rd_cnt;
    bit err_m;
    bit rst_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        filling_m  = -1;
        draining_m = -1;
        full_q.delete();
        for (int b = 0; b < NB; b++) len_m[b] = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        err_m  = 1'b0;
    endtask

    function automatic bit bank_empty(input int b);
        bank_empty = (filling_m != b) && (draining_m != b);
        foreach (full_q[i]) if (full_q[i] == b) bank_empty = 1'b0;
    endfunction

    function automatic bit valid_m();
        valid_m = (full_q.size() > 0) && (draining_m < 0) && (full_q[0] == rd_cnt % NB);
    endfunction

    task automatic check_outputs();
        int ea, ec, ew;
        check_eq("prod_gnt", 32'(prod_gnt), 32'(filling_m >= 0));
        if (filling_m >= 0) check_eq("prod_bank", 32'(prod_bank), 32'(filling_m));
        check_eq("cons_valid", 32'(cons_valid), 32'(valid_m()));
        check_eq("cons_bank", 32'(cons_bank), 32'(rd_cnt % NB));
        check_eq("cons_len", 32'(cons_len), 32'(len_m[rd_cnt % NB]));
        check_eq("full_cnt", 32'(full_cnt), 32'(full_q.size()));
        check_eq("err", 32'(err), 32'(err_m));
        for (int b = 0; b < NB; b++) begin
            if (filling_m == b) begin
                ea = int'(prod_A); ec = int'(prod_CEN); ew = int'(prod_WEN);
            end else if (draining_m == b) begin
                ea = int'(cons_A); ec = int'(cons_CEN); ew = 1;
            end else begin
                ea = 0; ec = 1; ew = 1;
            end
            check_eq($sformatf("buf_A[%0d]", b), 32'(buf_A[b*AW +: AW]), 32'(ea));
            check_eq($sformatf("buf_CEN[%0d]", b), 32'(buf_CEN[b]), 32'(ec));
            check_eq($sformatf("buf_WEN[%0d]", b), 32'(buf_WEN[b]), 32'(ew));
        end
    endtask

    task automatic model_step();
        bit gnt, dr, v, e_wr;
        if (clear) begin
            model_reset();
        end else begin
            gnt  = filling_m >= 0;
            dr   = draining_m >= 0;
            v    = valid_m();
            e_wr = bank_empty(wr_cnt % NB);
            if ((prod_done && !gnt) || (cons_done && !dr) || (cons_req && !v) ||
                (!prod_CEN && !gnt) || (!cons_CEN && !dr)) err_m = 1'b1;
            if (cons_req && v) begin
                draining_m = full_q.pop_front();
            end else if (cons_done && dr) begin
                draining_m = -1;
                rd_cnt++;
            end
            if (prod_req && !gnt && e_wr) begin
                filling_m = wr_cnt % NB;
            end else if (prod_done && gnt) begin
                len_m[filling_m] = int'(prod_len);
                if (prod_len != 0) begin
                    full_q.push_back(filling_m);
                    wr_cnt++;
                end
                filling_m = -1;
            end
        end
    endtask

    task automatic gen_inputs();
        bit gnt, dr, v;
        int r;
        gnt = filling_m >= 0;
        dr  = draining_m >= 0;
        v   = valid_m();
        prod_req  = 1'($urandom_range(0, 1));
        prod_done = gnt && ($urandom_range(0, 3) == 0);
        prod_len  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 128));
        prod_A    = 7'($urandom);
        prod_CEN  = gnt ? 1'($urandom) : 1'b1;
        prod_WEN  = 1'($urandom);
        cons_req  = v && ($urandom_range(0, 1) == 1);
        cons_done = dr && ($urandom_range(0, 2) == 0);
        cons_A    = 7'($urandom);
        cons_CEN  = dr ? 1'($urandom) : 1'b1;
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
            case ($urandom_range(0, 4))
                0: prod_done = 1'b1;
                1: cons_done = 1'b1;
                2: cons_req  = 1'b1;
                3: prod_CEN  = 1'b0;
                default: cons_CEN = 1'b0;
            endcase
        end
        clear = ($urandom_range(0, 99) < 2);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0;
        prod_req = 1'b0; prod_done = 1'b0; prod_len = 8'd0; prod_A = 7'd0;
        prod_CEN = 1'b1; prod_WEN = 1'b1;
        cons_req = 1'b0; cons_done = 1'b0; cons_A = 7'd0; cons_CEN = 1'b1;
        rst_done = 1'b0;
        model_reset();
        #23;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            gen_inputs();
            #1;
            check_outputs();
            if (!rst_done && cyc >= 2000 && draining_m >= 0) begin
                // Asynchronous reset in the middle of a drain.
                rst_done = 1'b1;
                rst = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(posedge clk);
                #2;
                check_outputs();
                rst = 1'b1;
            end else begin
                model_step();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
